// File: rtl/logic_unit_pkg.sv
// ----------------------------------------------------------------------------
// logic_unit_pkg
// Shared types and helpers for the logic-unit arbiter slice.
//   op_e     : 2-bit operation code (AND, OR, XOR, NOT a)
//   state_e  : arbiter sequencing states (IDLE -> EXEC -> RESP)
//   apply_op : single-bit evaluation of an op; the datapath replicates it
//              across the operand width, since every op is purely bitwise
// ----------------------------------------------------------------------------
package logic_unit_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOT = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Every op works bit-by-bit, so a one-bit helper keeps the function
   // independent of the operand width chosen by each instance.
   function automatic logic apply_op(input op_e op, input logic a, input logic b);
      logic y;
      y = 1'b0;
      case (op)
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOT: y = ~a;
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/bitwise_logic_unit.sv
// ----------------------------------------------------------------------------
// bitwise_logic_unit
// Purely combinational shared logic datapath.
// Ports:
//   op  in  op_e         operation select (AND, OR, XOR, NOT a)
//   a   in  WIDTH        operand a
//   b   in  WIDTH        operand b (no effect for NOT)
//   y   out WIDTH        result, exactly WIDTH bits, no carry or sign
// ----------------------------------------------------------------------------
module bitwise_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // One copy of the single-bit evaluator per result bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i] = apply_op(op, a[i], b[i]);
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter
// Shares one bitwise logic unit among N_REQ requesters with round-robin
// arbitration. Each operation is captured in IDLE, evaluated in EXEC and the
// registered result is held in RESP until the owner accepts it.
// Ports:
//   clk         in   1              rising-edge clock
//   rst_n       in   1              asynchronous active-low reset
//   req_valid   in   N_REQ          request pending per requester
//   req_ready   out  N_REQ          request accepted (one-hot or zero)
//   req_op      in   2*N_REQ        op per requester
//   req_a       in   WIDTH*N_REQ    operand a per requester
//   req_b       in   WIDTH*N_REQ    operand b per requester
//   resp_valid  out  N_REQ          result valid for the owner (one-hot/zero)
//   resp_ready  in   N_REQ          requester accepts result
//   resp_y      out  WIDTH          registered result, broadcast
//   grant_id    out  $clog2(N_REQ)  current owner, meaningful while busy
//   busy        out  1              unit owned (EXEC or RESP)
//   op_count    out  CNT_W          completed-response counter, wraps
// ----------------------------------------------------------------------------
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [2*N_REQ-1:0]     req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]       resp_valid,
   input  logic [N_REQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]       resp_y,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy,
   output logic [CNT_W-1:0]       op_count
);

   state_e           state;
   state_e           state_n;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   win;
   logic             any_valid;
   logic             resp_hs;
   op_e              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] unit_y;

   // Round-robin pick: duplicate the request vector and shift it so the slot
   // after the last owner lands at bit 0; the lowest set bit then wins.
   // ptr+1 wrapping to 0 for power-of-two N_REQ gives the same rotation as
   // shifting by N_REQ, so both cases line up.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [IDW-1:0]   ptr);
      logic [2*N_REQ-1:0] rot;
      logic [IDW-1:0]     pick;
      rot  = {valid, valid} >> (ptr + 1'b1);
      pick = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            pick = IDW'((int'(ptr) + 1 + j) % N_REQ);
         end
      end
      return pick;
   endfunction

   assign any_valid = |req_valid;
   assign win       = rr_pick(req_valid, rr_ptr);
   assign resp_hs   = (state == S_RESP) && resp_ready[grant_id];
   assign busy      = (state != S_IDLE);

   // The single shared datapath always sees the captured operands; its
   // output is only registered during EXEC.
   bitwise_logic_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .y  (unit_y)
   );

   // State register for the IDLE -> EXEC -> RESP sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and handshake outputs. req_ready is also gated by rst_n so
   // every output reads zero while reset is held, even with requests pending.
   always_comb begin
      state_n    = state;
      req_ready  = '0;
      resp_valid = '0;
      case (state)
         S_IDLE: begin
            if (rst_n && any_valid) begin
               req_ready[win] = 1'b1;
               state_n        = S_EXEC;
            end
         end
         S_EXEC: begin
            state_n = S_RESP;
         end
         S_RESP: begin
            resp_valid[grant_id] = 1'b1;
            if (resp_ready[grant_id]) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Datapath registers: capture the winner's request on the IDLE handshake,
   // register the unit result in EXEC, and on the response handshake move the
   // round-robin pointer to the finished owner and count the completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OP_AND;
         a_q      <= '0;
         b_q      <= '0;
         grant_id <= '0;
         resp_y   <= '0;
         rr_ptr   <= IDW'(N_REQ - 1);
         op_count <= '0;
      end else begin
         if (state == S_IDLE && any_valid) begin
            op_q     <= op_e'(req_op[win*2 +: 2]);
            a_q      <= req_a[win*WIDTH +: WIDTH];
            b_q      <= req_b[win*WIDTH +: WIDTH];
            grant_id <= win;
         end
         if (state == S_EXEC) begin
            resp_y <= unit_y;
         end
         if (resp_hs) begin
            rr_ptr   <= grant_id;
            op_count <= op_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Directed self-checking bench for logic_unit_arbiter (N_REQ=4, WIDTH=4,
// CNT_W=4 so the counter wrap is reachable quickly).
// ----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  resp_valid;
   logic [3:0]  resp_ready;
   logic [3:0]  resp_y;
   logic [1:0]  grant_id;
   logic        busy;
   logic [3:0]  op_count;

   int          checks;
   int          failures;
   logic [3:0]  expCount;

   // Per-requester operation table with hand-computed results.
   logic [1:0]  tOp [4];
   logic [3:0]  tA  [4];
   logic [3:0]  tB  [4];
   logic [3:0]  tY  [4];

   logic_unit_arbiter #(
      .N_REQ (4),
      .WIDTH (4),
      .CNT_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_y     (resp_y),
      .grant_id   (grant_id),
      .busy       (busy),
      .op_count   (op_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
      end
   endtask

   // Load one requester's operands from the table.
   task automatic applyStimulus(input int id);
      req_op[id*2 +: 2] = tOp[id];
      req_a[id*4 +: 4]  = tA[id];
      req_b[id*4 +: 4]  = tB[id];
   endtask

   // Advance one cycle and land on the falling edge.
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Walk one full operation for requester id starting in IDLE; resp_ready
   // for id must already be high. keepValid=0 drops the request during RESP.
   task automatic runOp(input int id, input logic keepValid);
      #1;
      checkOutput("idle_req_ready", req_ready, 32'(1 << id));
      stepCycle();
      checkOutput("exec_busy", busy, 1);
      checkOutput("exec_grant_id", grant_id, id);
      checkOutput("exec_resp_valid", resp_valid, 0);
      stepCycle();
      checkOutput("resp_valid", resp_valid, 32'(1 << id));
      checkOutput("resp_y", resp_y, tY[id]);
      if (!keepValid) req_valid[id] = 1'b0;
      stepCycle();
      expCount = expCount + 4'd1;
      checkOutput("op_count", op_count, expCount);
      checkOutput("idle_busy", busy, 0);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      expCount   = 4'd0;
      tOp[0] = 2'b00; tA[0] = 4'b1100; tB[0] = 4'b1010; tY[0] = 4'b1000;
      tOp[1] = 2'b10; tA[1] = 4'b1111; tB[1] = 4'b0011; tY[1] = 4'b1100;
      tOp[2] = 2'b11; tA[2] = 4'b0101; tB[2] = 4'b1111; tY[2] = 4'b1010;
      tOp[3] = 2'b01; tA[3] = 4'b0001; tB[3] = 4'b1000; tY[3] = 4'b1001;
      req_op = '0; req_a = '0; req_b = '0;
      for (int i = 0; i < 4; i++) applyStimulus(i);
      resp_ready = 4'b0000;

      // Reset with a request already pending: all outputs must stay low.
      rst_n     = 1'b0;
      req_valid = 4'b0001;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_y", resp_y, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_op_count", op_count, 0);

      // Single AND from requester 0.
      rst_n      = 1'b1;
      resp_ready = 4'b0001;
      runOp(0, 1'b0);
      #1;
      checkOutput("after_single_req_ready", req_ready, 0);

      // All requesters valid continuously: grants 0,1,2,3,0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      expCount   = 4'd0;
      req_valid  = 4'b1111;
      resp_ready = 4'b1111;
      runOp(0, 1'b1);
      runOp(1, 1'b1);
      runOp(2, 1'b1);
      runOp(3, 1'b1);
      runOp(0, 1'b1);

      // Requester 2 NOT with the response held off for 10 cycles while the
      // others request and raise their own resp_ready.
      req_valid  = 4'b0100;
      resp_ready = 4'b0000;
      #1;
      checkOutput("hold_req_ready", req_ready, 32'b0100);
      stepCycle();
      stepCycle();
      req_valid  = 4'b1111;
      resp_ready = 4'b1011;
      for (int c = 0; c < 10; c++) begin
         #1;
         checkOutput("hold_resp_y", resp_y, 4'b1010);
         checkOutput("hold_resp_valid", resp_valid, 32'b0100);
         checkOutput("hold_req_ready", req_ready, 0);
         checkOutput("hold_busy", busy, 1);
         stepCycle();
      end
      req_valid  = 4'b0000;
      resp_ready = 4'b0100;
      stepCycle();
      expCount = expCount + 4'd1;
      checkOutput("hold_op_count", op_count, expCount);

      // Reset during EXEC with requester 1 owning the unit.
      req_valid = 4'b0010;
      #1;
      checkOutput("mid_req_ready", req_ready, 32'b0010);
      stepCycle();
      checkOutput("mid_grant_id", grant_id, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_grant_id", grant_id, 0);
      checkOutput("mid_rst_resp_valid", resp_valid, 0);
      checkOutput("mid_rst_op_count", op_count, 0);
      checkOutput("mid_rst_req_ready", req_ready, 0);
      @(negedge clk);
      req_valid  = 4'b0011;
      resp_ready = 4'b1111;
      rst_n      = 1'b1;
      expCount   = 4'd0;
      runOp(0, 1'b0);

      // Seventeen more operations walk the 4-bit counter through 15 -> 0.
      req_valid = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         runOp((k + 1) % 4, 1'b1);
      end
      checkOutput("wrap_op_count", op_count, 4'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
